// File: rtl/or_tree_pkg.sv
`default_nettype none
// ============================================================================
// Module      : or_tree_pkg
// Description : Shared constants and helpers for the shared OR-tree arbiter.
//               NUM_OPS fixes the bundle size (operands per request) and
//               clog2_min1 sizes the requester ID tag, never below one bit.
// Revision    : 1.0 - initial release
// ============================================================================
package or_tree_pkg;

    localparam int NUM_OPS = 4;

    // ID tag width for n requesters; a 1-bit tag is kept even when n <= 2
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin grant. Searches req_i upward from
//               ptr_i (modulo NUM_REQ) and grants the first active request.
//               No grant is produced while en_i is low.
// Ports       : req_i       - request vector
//               ptr_i       - search start index (highest priority)
//               en_i        - grant enable
//               grant_o     - one-hot grant, all zero when nothing granted
//               grant_idx_o - binary index of the grant (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o
);

    logic            w_found;
    logic [ID_W-1:0] w_idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        w_found     = 1'b0;
        w_idx       = '0;
        if (en_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_idx = ID_W'((int'(ptr_i) + k) % NUM_REQ);
                if (!w_found && req_i[w_idx]) begin
                    w_found        = 1'b1;
                    grant_o[w_idx] = 1'b1;
                    grant_idx_o    = w_idx;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/or_tree_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : or_tree_arbiter
// Description : One 2-stage, 4-operand OR tree shared by NUM_REQ requesters.
//               A round-robin arbiter admits one bundle per cycle; results
//               leave tagged with the requester ID on a valid/ready port
//               with full backpressure and no bubbles.
// Ports       : clk       - clock, rising edge
//               rst_n     - asynchronous active-low reset
//               req_valid - per-requester bundle valid
//               req_ready - per-requester accept (one-hot or zero)
//               req_data  - bundles; requester i at [i*4*WIDTH +: 4*WIDTH],
//                           operand k at [k*WIDTH +: WIDTH] within it
//               out_valid - result valid
//               out_ready - downstream accept
//               out_data  - op0|op1|op2|op3 of the bundle
//               out_id    - requester index owning the result
// Revision    : 1.0 - initial release
// ============================================================================
module or_tree_arbiter
    import or_tree_pkg::*;
#(
    parameter  int WIDTH   = 1,
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*NUM_OPS*WIDTH-1:0] req_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic [ID_W-1:0]                  out_id
);

    localparam int BUNDLE_W = NUM_OPS * WIDTH;

    // Stage-1 payload: two partial ORs plus the owner tag
    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] p1;
        logic [WIDTH-1:0] p0;
    } s1_payload_t;

    logic                s1_valid_q;
    s1_payload_t         s1_q;
    s1_payload_t         s1_d;
    logic                s2_valid_q;
    logic [WIDTH-1:0]    s2_data_q;
    logic [WIDTH-1:0]    s2_data_d;
    logic [ID_W-1:0]     s2_id_q;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     rr_ptr_d;

    logic                w_adv1;
    logic                w_adv2;
    logic                w_fire;
    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_grant_idx;
    logic [BUNDLE_W-1:0] w_bundles [NUM_REQ];
    logic [BUNDLE_W-1:0] w_bundle;

    // A stage may load whenever the stage downstream of it is moving or empty
    assign w_adv2 = !s2_valid_q || out_ready;
    assign w_adv1 = !s1_valid_q || w_adv2;

    // rst_n gating keeps req_ready low for the whole time reset is held
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .en_i        (w_adv1 && rst_n),
        .grant_o     (w_grant),
        .grant_idx_o (w_grant_idx)
    );

    assign req_ready = w_grant;
    assign w_fire    = |(req_valid & w_grant);

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign w_bundles[i] = req_data[i*BUNDLE_W +: BUNDLE_W];
        end
    endgenerate

    assign w_bundle = w_bundles[w_grant_idx];

    always_comb begin
        s1_d    = '0;
        s1_d.p0 = w_bundle[0*WIDTH +: WIDTH] | w_bundle[1*WIDTH +: WIDTH];
        s1_d.p1 = w_bundle[2*WIDTH +: WIDTH] | w_bundle[3*WIDTH +: WIDTH];
        s1_d.id = w_grant_idx;
    end

    assign s2_data_d = s1_q.p0 | s1_q.p1;

    // Pointer moves one past the requester just served, wrapping to 0
    assign rr_ptr_d = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                           : w_grant_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
            rr_ptr_q   <= '0;
        end else begin
            if (w_adv1) begin
                s1_valid_q <= w_fire;
                s1_q       <= s1_d;
            end
            if (w_adv2) begin
                s2_valid_q <= s1_valid_q;
                s2_data_q  <= s2_data_d;
                s2_id_q    <= s1_q.id;
            end
            if (w_fire) begin
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_id    = s2_id_q;

endmodule
`default_nettype wire

// File: tb/tb_or_tree_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_or_tree_arbiter
// Description : Self-checking bench for or_tree_arbiter (WIDTH=8, NUM_REQ=4).
//               Directed scenarios plus a randomized run against a
//               queue-based reference of accepted bundles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_or_tree_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int BW      = 4 * WIDTH;

    typedef struct {
        logic [7:0] d;
        int         id;
        int         cyc;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*BW-1:0]   req_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [1:0]              out_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    or_tree_arbiter #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] b);
        req_data[i*BW +: BW] = b;
    endtask

    function automatic logic [7:0] or4(input logic [31:0] b);
        return b[7:0] | b[15:8] | b[23:16] | b[31:24];
    endfunction

    task automatic do_reset;
        req_valid = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        req_data  = '0;
        req_valid = 4'hF;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", out_data); end
        total++; if (out_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", out_id); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
        tick;
        req_valid = '0;
        rst_n     = 1'b1;
    endtask

    task automatic test_single;
        do_reset;
        req_data  = '0;
        set_req(2, 32'h08040201);
        req_valid = 4'b0100;
        @(negedge clk);
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b want=0100", req_ready); end
        tick;
        req_valid = '0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", out_valid); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_once got=%b want=0000", req_ready); end
        tick;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", out_valid); end
        total++; if (out_data !== 8'h0F) begin bad++; $display("FAIL single_data got=%h want=0f", out_data); end
        total++; if (out_id !== 2'd2) begin bad++; $display("FAIL single_id got=%0d want=2", out_id); end
        tick;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", out_valid); end
        tick;
    endtask

    task automatic test_round_robin;
        logic [31:0] b [NUM_REQ];
        logic [3:0]  ew;
        do_reset;
        for (int i = 0; i < NUM_REQ; i++) begin
            b[i] = $urandom();
            set_req(i, b[i]);
        end
        req_valid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 8) begin
                ew = 4'(1 << (c % 4));
                total++; if (req_ready !== ew) begin bad++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, req_ready, ew); end
            end
            if (c >= 2) begin
                total++;
                if (out_valid !== 1'b1 || out_id !== 2'((c - 2) % 4) || out_data !== or4(b[(c - 2) % 4])) begin
                    bad++;
                    $display("FAIL rr_out c=%0d got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                             c, out_valid, out_id, out_data, (c - 2) % 4, or4(b[(c - 2) % 4]));
                end
            end
            tick;
            if (c == 7) req_valid = '0;
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] bp [3];
        do_reset;
        for (int i = 0; i < 3; i++) bp[i] = $urandom();
        out_ready = 1'b0;
        set_req(0, bp[0]);
        req_valid = 4'b0001;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_acc0 got=%b want=0001", req_ready); end
        tick;
        set_req(0, bp[1]);
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_acc1 got=%b want=0001", req_ready); end
        tick;
        set_req(0, bp[2]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_full k=%0d got=%b want=0000", k, req_ready); end
            total++;
            if (out_valid !== 1'b1 || out_data !== or4(bp[0]) || out_id !== 2'd0) begin
                bad++;
                $display("FAIL bp_hold k=%0d got v=%b d=%h id=%0d want v=1 d=%h id=0", k, out_valid, out_data, out_id, or4(bp[0]));
            end
            tick;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_bubble got=%b want=0001", req_ready); end
            end
            total++;
            if (out_valid !== 1'b1 || out_data !== or4(bp[k]) || out_id !== 2'd0) begin
                bad++;
                $display("FAIL bp_order k=%0d got v=%b d=%h id=%0d want v=1 d=%h id=0", k, out_valid, out_data, out_id, or4(bp[k]));
            end
            tick;
            req_valid = '0;
        end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_dup got=%b want=0", out_valid); end
        tick;
    endtask

    task automatic test_wrap;
        do_reset;
        set_req(2, $urandom());
        req_valid = 4'b0100;
        @(negedge clk);
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL wrap_setup got=%b want=0100", req_ready); end
        tick;
        set_req(0, $urandom());
        set_req(3, $urandom());
        req_valid = 4'b1001;
        @(negedge clk);
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_g3 got=%b want=1000", req_ready); end
        tick;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_g0 got=%b want=0001", req_ready); end
        tick;
        @(negedge clk);
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_ptr1 got=%b want=1000", req_ready); end
        tick;
        req_valid = '0;
        repeat (3) tick;
    endtask

    task automatic test_async_reset;
        do_reset;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, $urandom());
        req_valid = 4'hF;
        out_ready = 1'b0;
        tick;
        tick;
        tick;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ar_full got=%b want=1", out_valid); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_async got=%b want=0", out_valid); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL ar_ready got=%b want=0000", req_ready); end
        tick;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL ar_first got=%b want=0001", req_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_flushed got=%b want=0", out_valid); end
        tick;
        req_valid = '0;
        repeat (3) tick;
    endtask

    task automatic test_random;
        localparam int NTX = 10000;
        logic [31:0]        pend_b [NUM_REQ];
        logic [NUM_REQ-1:0] pend;
        int                 waits  [NUM_REQ];
        exp_t               q [$];
        exp_t               e;
        int                 issued, done, ptr_m, cyc, g, hs;
        logic [3:0]         exp_ready;
        logic               exp_ov, prev_stall;
        logic [7:0]         prev_d;
        logic [1:0]         prev_id;
        do_reset;
        pend = '0; issued = 0; done = 0; ptr_m = 0; cyc = 0;
        prev_stall = 1'b0; prev_d = '0; prev_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            waits[i]  = 0;
            pend_b[i] = '0;
        end
        while (done < NTX && cyc < 60000) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && issued < NTX && $urandom_range(0, 3) != 0) begin
                    pend_b[i] = $urandom();
                    pend[i]   = 1'b1;
                    issued++;
                    set_req(i, pend_b[i]);
                end
            end
            req_valid = pend;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);

            // Expected grant: first pending requester from the pointer, when room exists
            exp_ready = '0;
            g = -1;
            if (q.size() < 2 || out_ready) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    int idx;
                    idx = (ptr_m + k) % NUM_REQ;
                    if (g < 0 && pend[idx]) g = idx;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rnd_grant cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready); end

            // Oldest accepted bundle is visible two cycles after acceptance
            exp_ov = (q.size() > 0) && (cyc - q[0].cyc >= 2);
            total++; if (out_valid !== exp_ov) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_ov); end

            if (prev_stall) begin
                total++;
                if (out_data !== prev_d || out_id !== prev_id) begin
                    bad++;
                    $display("FAIL rnd_hold cyc=%0d got d=%h id=%0d want d=%h id=%0d", cyc, out_data, out_id, prev_d, prev_id);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_id    = out_id;

            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rnd_extra cyc=%0d got id=%0d d=%h want none", cyc, out_id, out_data);
                end else begin
                    e = q.pop_front();
                    if (out_data !== e.d || int'(out_id) != e.id) begin
                        bad++;
                        $display("FAIL rnd_result cyc=%0d got d=%h id=%0d want d=%h id=%0d", cyc, out_data, out_id, e.d, e.id);
                    end
                    done++;
                end
            end

            hs = -1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) hs = i;
            end
            if (hs >= 0) begin
                e.d   = or4(pend_b[hs]);
                e.id  = hs;
                e.cyc = cyc;
                q.push_back(e);
                ptr_m     = (hs + 1) % NUM_REQ;
                pend[hs]  = 1'b0;
                waits[hs] = 0;
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (j != hs && pend[j]) begin
                        waits[j]++;
                        total++;
                        if (waits[j] > NUM_REQ) begin
                            bad++;
                            $display("FAIL rnd_starve req=%0d got waits=%0d want<=%0d", j, waits[j], NUM_REQ);
                        end
                    end
                end
            end
            cyc++;
            tick;
        end
        req_valid = '0;
        out_ready = 1'b1;
        total++;
        if (done != NTX || q.size() != 0) begin
            bad++;
            $display("FAIL rnd_complete got done=%0d left=%0d want done=%0d left=0", done, q.size(), NTX);
        end
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_wrap;
        test_async_reset;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/or_tree_arbiter.md
Name: or_tree_arbiter

Overview:
Shares one pipelined 4-operand OR tree between NUM_REQ requesters. Each requester submits a bundle of four WIDTH-bit operands over a valid/ready handshake. A round-robin arbiter grants one bundle per cycle into a 2-stage OR-tree pipeline. The block returns the OR of the four operands, tagged with the requester ID, on a valid/ready output with full backpressure. It sits between the OR datapath and multiple client blocks that would otherwise each need their own tree.

Parameters:
WIDTH, 1, bit width of each operand and of the result
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of the requester ID tag (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester bundle valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_data  in  NUM_REQ*4*WIDTH  requester i occupies bits [i*4*WIDTH +: 4*WIDTH]; operand k at [k*WIDTH +: WIDTH], k=0..3
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  WIDTH  op0|op1|op2|op3 of the granted bundle
out_id  out  ID_W  index of the requester the result belongs to

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_id=0, rr_ptr=0, req_ready=0.
- Pipeline: S1 registers p0=op0|op1, p1=op2|op3, id. S2 registers p0|p1, id. out_* are driven from S2 registers.
- Advance: adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2. S2 loads S1 when adv2; S1 loads the granted bundle when adv1.
- Grant: when adv1, grant the first i with req_valid[i], searching from rr_ptr upward modulo NUM_REQ. req_ready = one-hot of the granted index; all zeros when !adv1 or no request. Grant is combinational from req_valid, rr_ptr and adv1. Handshake completes when req_valid[i] & req_ready[i].
- rr_ptr <= (granted+1) mod NUM_REQ on every completed grant; unchanged otherwise. Wrap from NUM_REQ-1 to 0.
- Latency: a bundle accepted in cycle N appears on out_* in cycle N+2 when there is no backpressure. Throughput is 1 result/cycle.
- Stall: while out_valid & !out_ready, out_data and out_id hold stable. S1 also holds if full, and req_ready=0 when both stages are full. No result is dropped or duplicated.
- Simultaneous out handshake and full S1: S1 moves into S2 and a new grant enters S1 in the same cycle (bubble-free).
- Requesters must hold req_data stable while req_valid is high and not yet accepted. The block samples only on handshake.
- Lone requester: it is granted every cycle that adv1 is high.
- Reset mid-operation: all in-flight results are discarded, out_valid drops immediately (async), and rr_ptr returns to 0.
- Results are pure bitwise OR, with no width growth.

Decomposition:
- Package or_tree_pkg: localparam NUM_OPS=4; function clog2_min1 (ID width, minimum 1); typedef for the two-partial S1 payload struct.
- Sub-module rr_arbiter (NUM_REQ): inputs req, ptr, en; outputs grant one-hot, grant_idx. The remaining pipeline stays in or_tree_arbiter.

Test Plan:
- Reset then single request: NUM_REQ=4, WIDTH=8. Req 2 sends ops {01,02,04,08} with out_ready=1 → req_ready[2] high one cycle, and 2 cycles later out_data=0x0F, out_id=2.
- All four requesters valid continuously, out_ready=1 → grants cycle 0,1,2,3,0,… and out_id sequence 0,1,2,3,0 with no gaps.
- Backpressure: stream 3 bundles with out_ready=0 for 5 cycles → out_valid=1 holding the first result stable, req_ready=0 after two accepts, then all 3 results delivered in order once out_ready=1.
- Pointer wrap: rr_ptr=3, req_valid=4'b1001 → grant req 3, then req 0, and rr_ptr returns to 0 then 1.
- Async reset asserted with both stages full → out_valid=0 within the same cycle. After release, the first grant goes to req 0 when all requesters are valid.
- Random bundles with random valid/out_ready (10k transactions) vs. a per-ID scoreboard → every result equals the OR of its bundle, and no requester waits more than NUM_REQ grants.
